// File: rtl/cdb_arbiter_pkg.sv
// +----------------------------------------------------------------------------+
// | cdb_arbiter_pkg                                                            |
// | Shared widths and grant encoding for the CDB arbiter slice.                |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package cdb_arbiter_pkg;

    localparam int ROB_IDX_LN = 5;
    localparam int WORD_LN    = 32;

    typedef enum logic {
        CDB_SRC_ALU = 1'b0,
        CDB_SRC_LD  = 1'b1
    } cdb_src_e;

    // Round-robin: on a conflict the side that did not win last time goes next.
    function automatic cdb_src_e rr_other(input cdb_src_e last);
        return (last == CDB_SRC_ALU) ? CDB_SRC_LD : CDB_SRC_ALU;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cdb_fifo.sv
// +----------------------------------------------------------------------------+
// | cdb_fifo                                                                   |
// | Small per-source result queue with push, pop, flush, head, count and full. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module cdb_fifo #(
    parameter int FIFO_BIT = 1,
    parameter int WIDTH    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                push,
    input  logic [WIDTH-1:0]    push_data,
    input  logic                pop,
    output logic [WIDTH-1:0]    head,
    output logic [FIFO_BIT:0]   count,
    output logic                full
);

    localparam int DEPTH = 1 << FIFO_BIT;

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [WIDTH-1:0]    mem_d [DEPTH];
    logic [FIFO_BIT-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_BIT-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_BIT:0]   count_q, count_d;
    logic                w_push;
    logic                w_pop;

    assign full   = (count_q == (FIFO_BIT+1)'(DEPTH));
    assign count  = count_q;
    assign head   = mem_q[rd_ptr_q];
    assign w_push = push && !full;
    assign w_pop  = pop && (count_q != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// +----------------------------------------------------------------------------+
// | cdb_arbiter                                                                |
// | Round-robin share of the registered CDB between ALU and load unit.         |
// | Optional feature macro: CDB_BYPASS_EN (empty-queue push goes straight out).|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int FIFO_BIT = 1,
    parameter int ROB_BIT  = ROB_IDX_LN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                rob_rb_ena,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [ROB_BIT-1:0]  alu_src,
    input  logic [31:0]         alu_val,
    input  logic                alu_tk,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [ROB_BIT-1:0]  ld_src,
    input  logic [31:0]         ld_val,
    output logic                cdb_valid,
    output logic [ROB_BIT-1:0]  cdb_src,
    output logic [31:0]         cdb_val,
    output logic                cdb_tk,
    output logic                cdb_is_ld
);

    localparam int PW = ROB_BIT + WORD_LN + 1;

    logic [PW-1:0]     w_alu_in, w_ld_in, w_alu_head, w_ld_head, w_beat;
    logic [FIFO_BIT:0] w_alu_count, w_ld_count;
    logic              w_alu_full, w_ld_full;
    logic              w_alu_ne, w_ld_ne;
    logic              w_active;
    logic              w_alu_push, w_ld_push;
    logic              w_grant_vld, w_bypass;
    cdb_src_e          w_grant_sel;
    logic              w_pop_alu, w_pop_ld, w_enq_alu, w_enq_ld;

    logic               cdb_valid_q, cdb_valid_d;
    logic [ROB_BIT-1:0] cdb_src_q, cdb_src_d;
    logic [31:0]        cdb_val_q, cdb_val_d;
    logic               cdb_tk_q, cdb_tk_d;
    logic               cdb_is_ld_q, cdb_is_ld_d;
    cdb_src_e           last_grant_q, last_grant_d;

    // Load payloads carry tk=0 so the head never needs masking.
    assign w_alu_in = {alu_src, alu_val, alu_tk};
    assign w_ld_in  = {ld_src, ld_val, 1'b0};

    assign alu_ready  = rdy && !rob_rb_ena && !w_alu_full;
    assign ld_ready   = rdy && !rob_rb_ena && !w_ld_full;
    assign w_active   = rdy && !rob_rb_ena && !rst;
    assign w_alu_push = alu_valid && alu_ready;
    assign w_ld_push  = ld_valid && ld_ready;
    assign w_alu_ne   = (w_alu_count != '0);
    assign w_ld_ne    = (w_ld_count != '0);

    always_comb begin
        w_grant_vld = 1'b0;
        w_bypass    = 1'b0;
        w_grant_sel = last_grant_q;
        if (w_alu_ne && w_ld_ne) begin
            w_grant_vld = 1'b1;
            w_grant_sel = rr_other(last_grant_q);
        end else if (w_alu_ne) begin
            w_grant_vld = 1'b1;
            w_grant_sel = CDB_SRC_ALU;
        end else if (w_ld_ne) begin
            w_grant_vld = 1'b1;
            w_grant_sel = CDB_SRC_LD;
        end
`ifdef CDB_BYPASS_EN
        else if (w_alu_push || w_ld_push) begin
            w_grant_vld = 1'b1;
            w_bypass    = 1'b1;
            if (w_alu_push && w_ld_push) begin
                w_grant_sel = rr_other(last_grant_q);
            end else begin
                w_grant_sel = w_alu_push ? CDB_SRC_ALU : CDB_SRC_LD;
            end
        end
`endif
        if (!w_active) begin
            w_grant_vld = 1'b0;
            w_bypass    = 1'b0;
        end
    end

    assign w_pop_alu = w_grant_vld && !w_bypass && (w_grant_sel == CDB_SRC_ALU);
    assign w_pop_ld  = w_grant_vld && !w_bypass && (w_grant_sel == CDB_SRC_LD);
    assign w_enq_alu = w_alu_push && !(w_bypass && (w_grant_sel == CDB_SRC_ALU));
    assign w_enq_ld  = w_ld_push && !(w_bypass && (w_grant_sel == CDB_SRC_LD));

    assign w_beat = (w_grant_sel == CDB_SRC_ALU) ? (w_bypass ? w_alu_in : w_alu_head)
                                                 : (w_bypass ? w_ld_in  : w_ld_head);

    cdb_fifo #(
        .FIFO_BIT (FIFO_BIT),
        .WIDTH    (PW)
    ) u_alu_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (rob_rb_ena),
        .push      (w_enq_alu),
        .push_data (w_alu_in),
        .pop       (w_pop_alu),
        .head      (w_alu_head),
        .count     (w_alu_count),
        .full      (w_alu_full)
    );

    cdb_fifo #(
        .FIFO_BIT (FIFO_BIT),
        .WIDTH    (PW)
    ) u_ld_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (rob_rb_ena),
        .push      (w_enq_ld),
        .push_data (w_ld_in),
        .pop       (w_pop_ld),
        .head      (w_ld_head),
        .count     (w_ld_count),
        .full      (w_ld_full)
    );

    always_comb begin
        cdb_valid_d  = cdb_valid_q;
        cdb_src_d    = cdb_src_q;
        cdb_val_d    = cdb_val_q;
        cdb_tk_d     = cdb_tk_q;
        cdb_is_ld_d  = cdb_is_ld_q;
        last_grant_d = last_grant_q;
        if (w_active) begin
            cdb_valid_d = w_grant_vld;
            if (w_grant_vld) begin
                cdb_src_d    = w_beat[PW-1 -: ROB_BIT];
                cdb_val_d    = w_beat[WORD_LN:1];
                cdb_tk_d     = (w_grant_sel == CDB_SRC_LD) ? 1'b0 : w_beat[0];
                cdb_is_ld_d  = (w_grant_sel == CDB_SRC_LD);
                last_grant_d = w_grant_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || rob_rb_ena) begin
            cdb_valid_q  <= 1'b0;
            cdb_src_q    <= '0;
            cdb_val_q    <= '0;
            cdb_tk_q     <= 1'b0;
            cdb_is_ld_q  <= 1'b0;
            last_grant_q <= CDB_SRC_ALU;
        end else begin
            cdb_valid_q  <= cdb_valid_d;
            cdb_src_q    <= cdb_src_d;
            cdb_val_q    <= cdb_val_d;
            cdb_tk_q     <= cdb_tk_d;
            cdb_is_ld_q  <= cdb_is_ld_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_src   = cdb_src_q;
    assign cdb_val   = cdb_val_q;
    assign cdb_tk    = cdb_tk_q;
    assign cdb_is_ld = cdb_is_ld_q;

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_cdb_arbiter                                                             |
// | Scoreboard bench for cdb_arbiter with a queue-based reference model.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int RB    = ROB_IDX_LN;
    localparam int DEPTH = 2;

    logic          clk;
    logic          rst, rdy, rob_rb_ena;
    logic          alu_valid, alu_ready, alu_tk;
    logic [RB-1:0] alu_src;
    logic [31:0]   alu_val;
    logic          ld_valid, ld_ready;
    logic [RB-1:0] ld_src;
    logic [31:0]   ld_val;
    logic          cdb_valid, cdb_tk, cdb_is_ld;
    logic [RB-1:0] cdb_src;
    logic [31:0]   cdb_val;

    cdb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .rob_rb_ena (rob_rb_ena),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_src    (alu_src),
        .alu_val    (alu_val),
        .alu_tk     (alu_tk),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_src     (ld_src),
        .ld_val     (ld_val),
        .cdb_valid  (cdb_valid),
        .cdb_src    (cdb_src),
        .cdb_val    (cdb_val),
        .cdb_tk     (cdb_tk),
        .cdb_is_ld  (cdb_is_ld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int            edge_n;
        logic [RB-1:0] src;
        logic [31:0]   val;
        logic          tk;
        logic          is_ld;
    } beat_t;

    typedef struct {
        logic [RB-1:0] src;
        logic [31:0]   val;
        logic          tk;
    } ent_t;

    beat_t sb[$];
    ent_t  aq[$];
    ent_t  lq[$];
    bit    lg_ld;
    bit    m_valid;
    beat_t m_last;
    int    edge_n  = 0;
    int    n_pass  = 0;
    int    n_total = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    endfunction

    initial forever begin
        @(posedge clk);
        edge_n++;
    end

    // Monitor: every edge where cdb_valid is high must match the next expected beat.
    initial forever begin
        beat_t b;
        @(negedge clk);
        if (cdb_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_beat: got src %0h val %0h, expected no beat (edge %0d)",
                         cdb_src, cdb_val, edge_n);
            end else begin
                b = sb.pop_front();
                chk("beat_edge", 64'(edge_n), 64'(b.edge_n));
                chk("cdb_src", 64'(cdb_src), 64'(b.src));
                chk("cdb_val", 64'(cdb_val), 64'(b.val));
                chk("cdb_tk", 64'(cdb_tk), 64'(b.tk));
                chk("cdb_is_ld", 64'(cdb_is_ld), 64'(b.is_ld));
            end
        end else if (sb.size() > 0 && sb[0].edge_n <= edge_n) begin
            b = sb.pop_front();
            n_total++;
            $display("FAIL missed_beat: got cdb_valid %0b, expected src %0h at edge %0d",
                     cdb_valid, b.src, b.edge_n);
        end
    end

    // Drive one cycle of inputs and advance the reference model by one edge.
    task automatic step(input bit r, input bit rb_i, input bit rdy_i,
                        input bit av, input logic [RB-1:0] as_i, input logic [31:0] aval, input bit atk,
                        input bit lv, input logic [RB-1:0] ls_i, input logic [31:0] lval);
        bit    ar, lr, ap, lp, from_in;
        int    win;
        int    e;
        ent_t  ae, le, g;
        beat_t nb;
        rst = r; rob_rb_ena = rb_i; rdy = rdy_i;
        alu_valid = av; alu_src = as_i; alu_val = aval; alu_tk = atk;
        ld_valid = lv; ld_src = ls_i; ld_val = lval;
        #1;
        ar = rdy_i && !rb_i && (aq.size() < DEPTH);
        lr = rdy_i && !rb_i && (lq.size() < DEPTH);
        chk("alu_ready", 64'(alu_ready), 64'(ar));
        chk("ld_ready", 64'(ld_ready), 64'(lr));
        e = edge_n + 1;
        if (r || rb_i) begin
            aq.delete();
            lq.delete();
            lg_ld   = 1'b0;
            m_valid = 1'b0;
        end else if (!rdy_i) begin
            if (m_valid) begin
                nb = m_last;
                nb.edge_n = e;
                sb.push_back(nb);
            end
        end else begin
            ap = av && ar;
            lp = lv && lr;
            ae = '{as_i, aval, atk};
            le = '{ls_i, lval, 1'b0};
            win = -1;
            from_in = 1'b0;
            if (aq.size() > 0 && lq.size() > 0) win = lg_ld ? 0 : 1;
            else if (aq.size() > 0)             win = 0;
            else if (lq.size() > 0)             win = 1;
`ifdef CDB_BYPASS_EN
            if (win < 0 && (ap || lp)) begin
                from_in = 1'b1;
                if (ap && lp) win = lg_ld ? 0 : 1;
                else          win = ap ? 0 : 1;
            end
`endif
            g = ae;
            if (win == 0) begin
                if (from_in) begin g = ae; ap = 1'b0; end
                else g = aq.pop_front();
            end else if (win == 1) begin
                if (from_in) begin g = le; lp = 1'b0; end
                else g = lq.pop_front();
            end
            if (ap) aq.push_back(ae);
            if (lp) lq.push_back(le);
            if (win >= 0) begin
                m_valid = 1'b1;
                m_last  = '{e, g.src, g.val, (win == 1) ? 1'b0 : g.tk, (win == 1)};
                sb.push_back(m_last);
                lg_ld   = (win == 1);
            end else begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1, 0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic chk_cleared(string tag);
        chk({tag, "_valid"}, 64'(cdb_valid), 64'(0));
        chk({tag, "_src"}, 64'(cdb_src), 64'(0));
        chk({tag, "_val"}, 64'(cdb_val), 64'(0));
        chk({tag, "_tk"}, 64'(cdb_tk), 64'(0));
        chk({tag, "_is_ld"}, 64'(cdb_is_ld), 64'(0));
    endtask

    initial begin
        step(1, 0, 0, 0, '0, '0, 0, 0, '0, '0);
        step(1, 0, 1, 0, '0, '0, 0, 0, '0, '0);
        chk_cleared("reset");

        // Single ALU beat.
        step(0, 0, 1, 1, RB'(5), 32'h11, 1, 0, '0, '0);
        idle(3);

        // Same-cycle conflict: load wins first after reset.
        step(0, 0, 1, 1, RB'(3), 32'h33, 1, 1, RB'(4), 32'h44);
        idle(3);

        // ALU back-to-back with load continuously pending.
        for (int i = 0; i < 6; i++)
            step(0, 0, 1, 1, RB'(10 + i), 32'hA00 + i, i[0], 1, RB'(20 + i), 32'hB00 + i);
        idle(6);

        // Queue two, then flush with a simultaneous ALU push.
        step(0, 0, 1, 1, RB'(1), 32'h101, 0, 1, RB'(2), 32'h202);
        step(0, 0, 1, 1, RB'(6), 32'h606, 1, 1, RB'(8), 32'h808);
        step(0, 1, 1, 1, RB'(9), 32'h909, 1, 0, '0, '0);
        chk_cleared("flush");
        idle(4);

        // Stall while a beat is on the bus.
        step(0, 0, 1, 1, RB'(7), 32'h77, 1, 0, '0, '0);
        step(0, 0, 1, 1, RB'(12), 32'hC1, 0, 1, RB'(13), 32'hD1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, RB'(14), 32'hEE, 1, 1, RB'(15), 32'hFF);
        idle(5);

        for (int i = 0; i < 600; i++) begin
            bit r, rb_i, rdy_i;
            r     = ($urandom_range(0, 99) == 0);
            rb_i  = ($urandom_range(0, 29) == 0);
            rdy_i = ($urandom_range(0, 7) != 0);
            step(r, rb_i, rdy_i,
                 ($urandom_range(0, 2) != 0), RB'($urandom), $urandom, 1'($urandom),
                 ($urandom_range(0, 2) != 0), RB'($urandom), $urandom);
        end

        idle(8);
        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
